// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - signal bundle between dcache_ctrl, cache access logic and the coherence bus
// hit_count is present only when HIT_COUNT_EN is defined.
interface dcache_ctrl_if #(
  parameter int IDX_W       = 3,
  parameter int TAG_W       = 26,
  parameter int FLUSH_CNT_W = 4
);
  logic                   dmemREN;
  logic                   dmemWEN;
  logic                   halt;
  logic                   miss;
  logic [31:0]            dmemaddr;
  logic                   vic_dirty;
  logic [TAG_W-1:0]       vic_tag;
  logic [63:0]            vic_data;
  logic                   ccwait;
  logic [31:0]            ccsnoopaddr;
  logic                   snoop_hit_dirty;
  logic [63:0]            snoop_data;
  logic                   frame_dirty;
  logic [TAG_W-1:0]       frame_tag;
  logic [63:0]            frame_data;
  logic                   dwait;
  logic                   dREN;
  logic                   dWEN;
  logic [31:0]            daddr;
  logic [31:0]            dstore;
  logic                   ccwrite;
  logic                   cctrans;
  logic                   fill_en;
  logic                   fill_off;
  logic                   clean_en;
  logic [FLUSH_CNT_W-1:0] flush_frame;
  logic                   dhit;
  logic                   flushed;
`ifdef HIT_COUNT_EN
  logic [31:0]            hit_count;
`endif

  modport master (
    input  dmemREN, dmemWEN, halt, miss, dmemaddr,
    input  vic_dirty, vic_tag, vic_data,
    input  ccwait, ccsnoopaddr, snoop_hit_dirty, snoop_data,
    input  frame_dirty, frame_tag, frame_data, dwait,
    output dREN, dWEN, daddr, dstore, ccwrite, cctrans,
    output fill_en, fill_off, clean_en, flush_frame, dhit, flushed
`ifdef HIT_COUNT_EN
    , output hit_count
`endif
  );

  modport slave (
    output dmemREN, dmemWEN, halt, miss, dmemaddr,
    output vic_dirty, vic_tag, vic_data,
    output ccwait, ccsnoopaddr, snoop_hit_dirty, snoop_data,
    output frame_dirty, frame_tag, frame_data, dwait,
    input  dREN, dWEN, daddr, dstore, ccwrite, cctrans,
    input  fill_en, fill_off, clean_en, flush_frame, dhit, flushed
`ifdef HIT_COUNT_EN
    , input hit_count
`endif
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - dcache sequencing FSM: victim write-back, line fill, snoop forward, halt flush
// Optional HIT_COUNT_EN adds bus.hit_count (dhit cycles minus misses started from IDLE).
module dcache_ctrl #(
  parameter int IDX_W       = 3,
  parameter int TAG_W       = 26,
  parameter int FLUSH_CNT_W = 4
) (
  input logic           CLK,
  input logic           nRST,
  dcache_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, SNOOP, SWB0, SWB1, FLUSH, FWB0, FWB1, HALTED
  } state_t;

  state_t                 state, next_state, snoop_ret;
  logic [FLUSH_CNT_W-1:0] frame_cnt, next_cnt;
  logic                   done;
  logic                   req, off, cnt_last;
  logic [IDX_W-1:0]       req_idx, flush_idx;
  logic                   unused_addr;

  assign req         = bus.dmemREN | bus.dmemWEN;
  assign req_idx     = bus.dmemaddr[3 +: IDX_W];
  assign flush_idx   = frame_cnt[IDX_W-1:0];
  assign cnt_last    = &frame_cnt;
  // Snoops taken after the flush must land back in HALTED, not IDLE.
  assign snoop_ret   = done ? HALTED : IDLE;
  assign off         = (state == WB1) || (state == FETCH1) || (state == SWB1) || (state == FWB1);
  assign unused_addr = ^{bus.dmemaddr[2:0], bus.ccsnoopaddr[2:0]};

  assign bus.flush_frame = frame_cnt;
  assign bus.flushed     = done;

  function automatic logic [31:0] word_of(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      frame_cnt <= next_cnt;
      if (next_state == HALTED) done <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = frame_cnt;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ccwrite  = 1'b0;
    bus.cctrans  = 1'b0;
    bus.fill_en  = 1'b0;
    bus.fill_off = 1'b0;
    bus.clean_en = 1'b0;
    bus.dhit     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so every output reads 0 while nRST is held low.
        bus.dhit = nRST & req & ~bus.miss & ~bus.halt;
        if (bus.ccwait)          next_state = SNOOP;
        else if (bus.halt)       next_state = FLUSH;
        else if (req & bus.miss) next_state = bus.vic_dirty ? WB0 : FETCH0;
      end
      WB0, WB1: begin
        bus.dWEN    = 1'b1;
        bus.cctrans = 1'b1;
        bus.daddr   = {bus.vic_tag, req_idx, off, 2'b00};
        bus.dstore  = word_of(bus.vic_data, off);
        if (!bus.dwait) next_state = (state == WB0) ? WB1 : FETCH0;
      end
      FETCH0, FETCH1: begin
        bus.dREN     = 1'b1;
        bus.cctrans  = 1'b1;
        bus.ccwrite  = bus.dmemWEN;
        bus.daddr    = {bus.dmemaddr[31:3], off, 2'b00};
        bus.fill_en  = ~bus.dwait;
        bus.fill_off = off;
        if (!bus.dwait) next_state = (state == FETCH0) ? FETCH1 : IDLE;
      end
      SNOOP: next_state = bus.snoop_hit_dirty ? SWB0 : snoop_ret;
      SWB0, SWB1: begin
        bus.dWEN    = 1'b1;
        bus.cctrans = 1'b1;
        bus.daddr   = {bus.ccsnoopaddr[31:3], off, 2'b00};
        bus.dstore  = word_of(bus.snoop_data, off);
        if (!bus.dwait) begin
          bus.clean_en = (state == SWB1);
          next_state   = (state == SWB0) ? SWB1 : snoop_ret;
        end
      end
      FLUSH: begin
        if (bus.frame_dirty) next_state = FWB0;
        else begin
          next_cnt = frame_cnt + 1'b1;
          if (cnt_last) next_state = HALTED;
        end
      end
      FWB0, FWB1: begin
        bus.dWEN    = 1'b1;
        bus.cctrans = 1'b1;
        bus.daddr   = {bus.frame_tag, flush_idx, off, 2'b00};
        bus.dstore  = word_of(bus.frame_data, off);
        if (!bus.dwait) begin
          if (state == FWB0) next_state = FWB1;
          else begin
            bus.clean_en = 1'b1;
            next_cnt     = frame_cnt + 1'b1;
            next_state   = cnt_last ? HALTED : FLUSH;
          end
        end
      end
      HALTED: if (bus.ccwait) next_state = SNOOP;
      default: next_state = IDLE;
    endcase
  end

`ifdef HIT_COUNT_EN
  logic [31:0] hit_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt <= '0;
    end else if (state != HALTED) begin
      if (bus.dhit)
        hit_cnt <= hit_cnt + 32'd1;
      else if (state == IDLE && (next_state == WB0 || next_state == FETCH0))
        hit_cnt <= hit_cnt - 32'd1;
    end
  end

  assign bus.hit_count = hit_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  dcache_ctrl_if bus ();
  dcache_ctrl dut (.CLK(CLK), .nRST(nRST), .bus(bus.master));

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          ccw;
  } word_t;

  word_t       exp_q[$];
  word_t       mon_w;
  int          errors = 0, checks = 0;
  int          clean_exp = 0, clean_seen = 0, max_ff = 0;
  bit          abort_mode = 1'b0;
  logic [31:0] hc_model = '0;
  logic        fdirty[16];
  logic [25:0] ftag[16];
  logic [63:0] fdata[16];

  assign bus.frame_dirty = fdirty[bus.flush_frame];
  assign bus.frame_tag   = ftag[bus.flush_frame];
  assign bus.frame_data  = fdata[bus.flush_frame];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d, 1'b0});
  endtask

  task automatic push_rd(input logic [31:0] a, input bit ccw);
    exp_q.push_back('{1'b0, a, 32'h0, ccw});
  endtask

  // Monitor: every completed bus word is popped from the scoreboard.
  always @(negedge CLK) begin
    if (nRST) begin
      if (int'(bus.flush_frame) > max_ff) max_ff = int'(bus.flush_frame);
      if (bus.clean_en) clean_seen++;
      if (bus.dREN && bus.dWEN) chk("both_dren_dwen", 1, 0);
      if (!bus.dREN || bus.dwait) chk("fill_en_idle", bus.fill_en, 0);
      if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bus_word_addr", bus.daddr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_w = exp_q.pop_front();
          chk("bus_dir_is_write", bus.dWEN, mon_w.we);
          chk("bus_addr", bus.daddr, mon_w.addr);
          if (mon_w.we) begin
            chk("bus_wdata", bus.dstore, mon_w.data);
          end else begin
            chk("ccwrite", bus.ccwrite, mon_w.ccw);
            chk("fill_en", bus.fill_en, 1);
            chk("fill_off", bus.fill_off, mon_w.addr[2]);
          end
        end
      end
    end
  end

  // Memory latency: random dwait, or pinned high to freeze the second fill word.
  initial begin
    bus.dwait = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (abort_mode && exp_q.size() == 1) bus.dwait = 1'b1;
      else bus.dwait = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.miss    = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cyc();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_words_outstanding"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_ctrl_outputs"}, {bus.dREN, bus.dWEN, bus.ccwrite, bus.cctrans, bus.fill_en,
        bus.fill_off, bus.clean_en, bus.flush_frame, bus.dhit, bus.flushed}, 0);
    chk({t, "_daddr_dstore"}, {bus.daddr, bus.dstore}, 0);
  endtask

  task automatic do_hit(input bit we, input logic [31:0] a);
    bus.dmemREN = !we;
    bus.dmemWEN = we;
    bus.dmemaddr = a;
    bus.miss = 1'b0;
    @(negedge CLK);
    chk("hit_dhit", bus.dhit, 1);
    cyc();
    clear_req();
    hc_model = hc_model + 1;
  endtask

  task automatic do_miss(input bit we, input logic [31:0] a, input bit vd, input logic [25:0] vtag,
                         input logic [63:0] vdata, input bit snp, input logic [31:0] sa,
                         input bit sd, input logic [63:0] sdata);
    bus.dmemREN = !we;
    bus.dmemWEN = we;
    bus.dmemaddr = a;
    bus.miss = 1'b1;
    bus.vic_dirty = vd;
    bus.vic_tag = vtag;
    bus.vic_data = vdata;
    bus.ccwait = snp;
    bus.ccsnoopaddr = sa;
    bus.snoop_hit_dirty = sd;
    bus.snoop_data = sdata;
    if (snp && sd) begin
      push_wr({sa[31:3], 3'b000}, sdata[31:0]);
      push_wr({sa[31:3], 3'b100}, sdata[63:32]);
      clean_exp++;
    end
    if (vd) begin
      push_wr({vtag, a[5:3], 3'b000}, vdata[31:0]);
      push_wr({vtag, a[5:3], 3'b100}, vdata[63:32]);
    end
    push_rd({a[31:3], 3'b000}, we);
    push_rd({a[31:3], 3'b100}, we);
    hc_model = hc_model - 1;
    cyc();
    bus.ccwait = 1'b0;
    wait_empty("miss");
    bus.miss = 1'b0;
    @(negedge CLK);
    chk("retry_dhit", bus.dhit, 1);
    cyc();
    clear_req();
    hc_model = hc_model + 1;
    chk("clean_en_count", clean_seen, clean_exp);
  endtask

  task automatic do_snoop(input logic [31:0] sa, input bit sd, input logic [63:0] sdata);
    bus.ccwait = 1'b1;
    bus.ccsnoopaddr = sa;
    bus.snoop_hit_dirty = sd;
    bus.snoop_data = sdata;
    if (sd) begin
      push_wr({sa[31:3], 3'b000}, sdata[31:0]);
      push_wr({sa[31:3], 3'b100}, sdata[63:32]);
      clean_exp++;
    end
    cyc();
    bus.ccwait = 1'b0;
    if (sd) wait_empty("snoop");
    else cyc();
    chk("snoop_clean_en_count", clean_seen, clean_exp);
  endtask

  initial begin
    int n;
    int r;
    logic [3:0] fv;
    clear_req();
    bus.halt = 1'b0;
    bus.dmemaddr = '0;
    bus.vic_dirty = 1'b0;
    bus.vic_tag = '0;
    bus.vic_data = '0;
    bus.ccwait = 1'b0;
    bus.ccsnoopaddr = '0;
    bus.snoop_hit_dirty = 1'b0;
    bus.snoop_data = '0;
    for (int f = 0; f < 16; f++) begin
      fdirty[f] = 1'b0;
      ftag[f]   = 26'($urandom);
      fdata[f]  = {$urandom, $urandom};
    end
    bus.dmemREN = 1'b1;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    bus.dmemREN = 1'b0;
    cyc();

    repeat (3) do_hit(1'b0, $urandom & 32'hFFFF_FFFC);
`ifdef HIT_COUNT_EN
    chk("hit_count_after_3_hits", bus.hit_count, 3);
`endif
    do_miss(1'b0, 32'h0000_0040, 1'b0, 26'h0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0);
    do_miss(1'b1, 32'h0000_1010, 1'b1, 26'h1, 64'hBBBB_BBBB_AAAA_AAAA, 1'b0, 32'h0, 1'b0, 64'h0);
    do_miss(1'b0, 32'h0000_2008, 1'b0, 26'h0, 64'h0, 1'b1, 32'h80, 1'b1, 64'h2222_2222_1111_1111);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)
        do_hit($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC);
      else if (r < 7)
        do_miss($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
                26'($urandom), {$urandom, $urandom}, 1'b0, 32'h0, 1'b0, 64'h0);
      else if (r < 9)
        do_snoop($urandom, $urandom_range(0, 1), {$urandom, $urandom});
      else
        do_miss($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
                26'($urandom), {$urandom, $urandom}, 1'b1, $urandom, $urandom_range(0, 1),
                {$urandom, $urandom});
    end
`ifdef HIT_COUNT_EN
    chk("hit_count_random", bus.hit_count, hc_model);
`endif

    bus.dmemREN = 1'b1;
    bus.miss = 1'b1;
    bus.vic_dirty = 1'b0;
    bus.dmemaddr = 32'h0000_0340;
    push_rd(32'h340, 1'b0);
    push_rd(32'h344, 1'b0);
    abort_mode = 1'b1;
    n = 0;
    while (exp_q.size() != 1 && n < 200) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    @(negedge CLK);
    chk("abort_fetch1_dREN", bus.dREN, 1);
    chk("abort_fetch1_daddr", bus.daddr, 32'h344);
    #2 nRST = 1'b0;
    #1 chk_zero("async_abort");
    exp_q.delete();
    abort_mode = 1'b0;
    clear_req();
    hc_model = '0;
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
    do_hit(1'b1, 32'h0000_0100);
`ifdef HIT_COUNT_EN
    chk("hit_count_after_reset", bus.hit_count, hc_model);
`endif

    fdirty[3] = 1'b1;
    fdirty[12] = 1'b1;
    for (int f = 0; f < 16; f++) begin
      if (fdirty[f]) begin
        fv = 4'(f);
        push_wr({ftag[f], fv[2:0], 3'b000}, fdata[f][31:0]);
        push_wr({ftag[f], fv[2:0], 3'b100}, fdata[f][63:32]);
        clean_exp++;
      end
    end
    bus.halt = 1'b1;
    bus.dmemREN = 1'b1;
    @(negedge CLK);
    chk("halt_blocks_dhit", bus.dhit, 0);
    cyc();
    bus.dmemREN = 1'b0;
    wait_empty("flush");
    n = 0;
    while (!bus.flushed && n < 100) begin
      cyc();
      n++;
    end
    chk("flushed", bus.flushed, 1);
    chk("flush_frame_wrapped", bus.flush_frame, 0);
    chk("flush_frame_max", max_ff, 15);
    chk("flush_clean_en_count", clean_seen, clean_exp);
    repeat (5) cyc();
    chk("flushed_sticky", bus.flushed, 1);
    do_snoop(32'h0000_0C80, 1'b1, 64'h4444_4444_3333_3333);
    do_snoop(32'h0000_0D00, 1'b0, 64'h0);
    repeat (3) cyc();
    chk("flushed_after_snoop", bus.flushed, 1);
    chk("halted_no_bus", {bus.dREN, bus.dWEN}, 0);

    @(negedge CLK);
    #3 nRST = 1'b0;
    #1 chk_zero("final_reset");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
